g1_table_updater: RTL and testbench
===================================

# g1_table_updater

Write-side controller for one G1 search table. Accepts insert and flush commands over a valid/ready handshake, allocates table slots from a bump pointer, builds 60-bit chained entries, and drives the table's `we`/`din`/`search_index` write port. It owns the per-bucket chain-head registers that the search front-end reads to obtain the first `search_index` of each chain. One instance sits beside each G1 table, SUBSET_NUM × TABLE_NUM instances in total.

## Interface
- TABLE_ENTRY_SIZE, 154: highest table index; the table holds indices 0..TABLE_ENTRY_SIZE.
- INDEX_BIT_LEN, 11: slot index / ruleID width.
- COMMAND_BIT_LEN, 2: opcode width.
- ENTRY_DATA_WIDTH, 60: entry width.
- BUCKET_BIT_LEN, 4: chain-head selector width; 2^BUCKET_BIT_LEN head registers.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  updater can accept a command.
- cmd_op  in  COMMAND_BIT_LEN  opcode: 01 insert, 10 flush, 00 and 11 no-op.
- cmd_srcIP  in  32  source IP for insert.
- cmd_ruleID  in  INDEX_BIT_LEN  rule ID for insert.
- cmd_bucket  in  BUCKET_BIT_LEN  chain to insert into.
- we  out  1  table write enable.
- din  out  ENTRY_DATA_WIDTH  table write data.
- wr_index  out  INDEX_BIT_LEN  table write address; muxed onto `search_index` while `we`=1.
- done  out  1  one-cycle pulse when a command completes.
- err_full  out  1  one-cycle pulse with `done` when an insert found no free slot.
- free_count  out  INDEX_BIT_LEN  number of unallocated slots.
- head_rd_addr  in  BUCKET_BIT_LEN  head lookup address.
- head_rd_data  out  INDEX_BIT_LEN  registered chain-head index; 0 means the chain is empty.

## Operation
- Entry format:
  - [59:49] next index.
  - [48:38] ruleID.
  - [37:32] zero.
  - [31:0] srcIP.
- Index 0 is the null terminator and is never allocated. Allocatable slots are 1..TABLE_ENTRY_SIZE.
- State: `alloc_ptr` (INDEX_BIT_LEN+1 bits). Reset value is 1. The table is full when `alloc_ptr` > TABLE_ENTRY_SIZE.
- `free_count` = TABLE_ENTRY_SIZE+1−`alloc_ptr`. Reset value is TABLE_ENTRY_SIZE (154).
- FSM states:
  - IDLE: `cmd_ready`=1. A command is accepted on valid&ready.
    - Insert goes to INS.
    - Flush goes to FLUSH with walk counter 0.
    - No-op goes to ACK.
  - INS: one cycle.
    - Not full: `we`=1, `wr_index`=`alloc_ptr`, `din`={head[cmd_bucket], cmd_ruleID, 6'b0, cmd_srcIP}. At the closing edge, head[cmd_bucket]←`alloc_ptr` and `alloc_ptr`+1.
    - Full: `we`=0, `err_full`=1, nothing changes.
    - `done`=1 in both cases. Next state IDLE.
  - FLUSH: `we`=1, `wr_index`=walk counter, `din`=0. The counter increments each cycle.
    - On the cycle with counter = TABLE_ENTRY_SIZE: `done`=1, all heads←0, `alloc_ptr`←1, next state IDLE.
  - ACK: `done`=1, no write. Next state IDLE.
- Command fields are captured into registers at acceptance. Input changes after acceptance have no effect.
- `cmd_ready`=0 in every state except IDLE.
- Head read:
  - `head_rd_data` ← head[`head_rd_addr`] every clock, independent of FSM state.
  - When the same edge also writes that head, the read returns the pre-write value.
- Reset values: `cmd_ready`=1 (IDLE), `we`=0, `din`=0, `wr_index`=0, `done`=0, `err_full`=0, `head_rd_data`=0, all heads 0.
- Reset asserted mid-flush or mid-insert aborts the command immediately. No further writes occur. Table contents already written are left as-is; the next flush makes them consistent.

## Timing
- Acceptance edge at the end of cycle T.
- Insert: `we`/`done` high in cycle T+1; `cmd_ready` high again in T+2.
- Flush: `we` high in cycles T+1..T+1+TABLE_ENTRY_SIZE (155 writes at default). `done` is high in the last of those cycles. `cmd_ready` is high at T+2+TABLE_ENTRY_SIZE.
- No-op: `done` in T+1.
- Back-to-back inserts sustain one command per 2 cycles.
- `we`, `din`, `wr_index`, `done` and `err_full` are all registered state outputs. There is no combinational path from cmd_* to any of them.
- `head_rd_data` latency is 1 cycle.

## Test plan
- Reset, then insert srcIP 0x0A000001, ruleID 5, bucket 3 → in T+1: `we`=1, `wr_index`=1, `din`={11'd0, 11'd5, 6'd0, 32'h0A000001}, `done`=1. Afterwards head[3]=1 and `free_count`=153.
- Second insert into bucket 3 (srcIP 0x0A000002, ruleID 6) → `wr_index`=2, `din`[59:49]=1. Afterwards head[3]=2. A head read of bucket 3 returns 2 one cycle after the address is applied.
- Insert 154 rules, then a 155th → the 155th produces `done`=`err_full`=1 and `we`=0; `free_count`=0 and heads are unchanged.
- Flush after the fill above → exactly 155 write cycles to indices 0..154 with `din`=0, `done` on index 154. Afterwards all heads read 0 and `free_count`=154.
- Hold `cmd_valid`=1 with op 11 while ready → `done` without `we`. Hold an insert valid during INS → no second acceptance until `cmd_ready` returns.
- Assert `rst_n` low mid-flush at index 40 → `we` drops asynchronously, outputs return to reset values, and the next insert writes index 1.

Source files
------------

// File: rtl/g1_table_updater.sv
// Write-side controller for one G1 search table: bump-pointer slot allocation,
// chained entry construction, full-table flush and the per-bucket chain heads.
module g1_table_updater #(
  parameter int TABLE_ENTRY_SIZE = 154,
  parameter int INDEX_BIT_LEN    = 11,
  parameter int COMMAND_BIT_LEN  = 2,
  parameter int ENTRY_DATA_WIDTH = 60,
  parameter int BUCKET_BIT_LEN   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [COMMAND_BIT_LEN-1:0]  cmd_op,
  input  logic [31:0]                 cmd_srcIP,
  input  logic [INDEX_BIT_LEN-1:0]    cmd_ruleID,
  input  logic [BUCKET_BIT_LEN-1:0]   cmd_bucket,
  output logic                        we,
  output logic [ENTRY_DATA_WIDTH-1:0] din,
  output logic [INDEX_BIT_LEN-1:0]    wr_index,
  output logic                        done,
  output logic                        err_full,
  output logic [INDEX_BIT_LEN-1:0]    free_count,
  input  logic [BUCKET_BIT_LEN-1:0]   head_rd_addr,
  output logic [INDEX_BIT_LEN-1:0]    head_rd_data
);

  localparam int NB = 1 << BUCKET_BIT_LEN;
  localparam int PW = INDEX_BIT_LEN + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(TABLE_ENTRY_SIZE);
  localparam logic [PW-1:0] END_PTR  = PW'(TABLE_ENTRY_SIZE + 1);
  localparam logic [INDEX_BIT_LEN-1:0] LAST_IDX = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE);

  typedef enum logic [1:0] {IDLE, INS, FLUSH, ACK} state_t;

  state_t                                state_reg, state_next;
  logic [PW-1:0]                         alloc_ptr_reg, alloc_ptr_next;
  logic [BUCKET_BIT_LEN-1:0]             bucket_reg, bucket_next;
  logic [NB-1:0][INDEX_BIT_LEN-1:0]      head_reg, head_next;
  logic                                  we_reg, we_next;
  logic                                  done_reg, done_next;
  logic                                  err_full_reg, err_full_next;
  logic [ENTRY_DATA_WIDTH-1:0]           din_reg, din_next;
  logic [INDEX_BIT_LEN-1:0]              wr_index_reg, wr_index_next;
  logic [INDEX_BIT_LEN-1:0]              head_rd_data_reg;
  logic                                  head_wr, head_clr, full;

  assign full = (alloc_ptr_reg > LAST_PTR);

  // All write-port outputs are computed one cycle ahead and registered, so
  // nothing on cmd_* reaches them combinationally.
  always_comb begin
    state_next     = state_reg;
    alloc_ptr_next = alloc_ptr_reg;
    bucket_next    = bucket_reg;
    we_next        = 1'b0;
    done_next      = 1'b0;
    err_full_next  = 1'b0;
    din_next       = din_reg;
    wr_index_next  = wr_index_reg;
    head_wr        = 1'b0;
    head_clr       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          bucket_next = cmd_bucket;
          case (cmd_op)
            2'b01: begin
              state_next    = INS;
              done_next     = 1'b1;
              we_next       = !full;
              err_full_next = full;
              if (!full) begin
                wr_index_next = alloc_ptr_reg[INDEX_BIT_LEN-1:0];
                din_next      = ENTRY_DATA_WIDTH'({head_reg[cmd_bucket], cmd_ruleID, 6'b0, cmd_srcIP});
              end
            end
            2'b10: begin
              state_next    = FLUSH;
              we_next       = 1'b1;
              wr_index_next = '0;
              din_next      = '0;
              done_next     = (TABLE_ENTRY_SIZE == 0);
            end
            default: begin
              state_next = ACK;
              done_next  = 1'b1;
            end
          endcase
        end
      end
      INS: begin
        state_next = IDLE;
        if (we_reg) begin
          head_wr        = 1'b1;
          alloc_ptr_next = alloc_ptr_reg + 1'b1;
        end
      end
      FLUSH: begin
        if (wr_index_reg == LAST_IDX) begin
          state_next     = IDLE;
          head_clr       = 1'b1;
          alloc_ptr_next = PW'(1);
        end else begin
          we_next       = 1'b1;
          din_next      = '0;
          wr_index_next = wr_index_reg + 1'b1;
          done_next     = ((wr_index_reg + 1'b1) == LAST_IDX);
        end
      end
      ACK: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The slot being written becomes the new head; its entry already links to the old head.
  for (genvar gi = 0; gi < NB; gi++) begin : g_head
    assign head_next[gi] = head_clr ? '0 :
                           (head_wr && bucket_reg == BUCKET_BIT_LEN'(gi)) ? alloc_ptr_reg[INDEX_BIT_LEN-1:0] :
                           head_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      alloc_ptr_reg    <= PW'(1);
      bucket_reg       <= '0;
      head_reg         <= '0;
      we_reg           <= 1'b0;
      done_reg         <= 1'b0;
      err_full_reg     <= 1'b0;
      din_reg          <= '0;
      wr_index_reg     <= '0;
      head_rd_data_reg <= '0;
    end else begin
      state_reg        <= state_next;
      alloc_ptr_reg    <= alloc_ptr_next;
      bucket_reg       <= bucket_next;
      head_reg         <= head_next;
      we_reg           <= we_next;
      done_reg         <= done_next;
      err_full_reg     <= err_full_next;
      din_reg          <= din_next;
      wr_index_reg     <= wr_index_next;
      head_rd_data_reg <= head_reg[head_rd_addr];
    end
  end

  assign cmd_ready    = (state_reg == IDLE);
  assign we           = we_reg;
  assign din          = din_reg;
  assign wr_index     = wr_index_reg;
  assign done         = done_reg;
  assign err_full     = err_full_reg;
  assign head_rd_data = head_rd_data_reg;
  assign free_count   = INDEX_BIT_LEN'(END_PTR - alloc_ptr_reg);

endmodule

// File: tb/tb_g1_table_updater.sv
// Directed self-checking bench for g1_table_updater: insert, chain heads,
// full table, flush, no-op, back-to-back handshake and mid-flush reset.
module tb_g1_table_updater;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_srcIP;
  logic [10:0] cmd_ruleID;
  logic [3:0]  cmd_bucket;
  logic        we;
  logic [59:0] din;
  logic [10:0] wr_index;
  logic        done;
  logic        err_full;
  logic [10:0] free_count;
  logic [3:0]  head_rd_addr;
  logic [10:0] head_rd_data;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_head [16];
  logic [59:0] exp_din;

  g1_table_updater dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_srcIP(cmd_srcIP), .cmd_ruleID(cmd_ruleID),
    .cmd_bucket(cmd_bucket), .we(we), .din(din), .wr_index(wr_index),
    .done(done), .err_full(err_full), .free_count(free_count),
    .head_rd_addr(head_rd_addr), .head_rd_data(head_rd_data)
  );

  always #5 clk = ~clk;

  // Presents one command; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [31:0] ip,
                      input logic [10:0] rule, input logic [3:0] b);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 500) begin
      errors++;
      $display("FAIL send_ready_timeout got ready=%0b required 1", cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_srcIP  = ip;
    cmd_ruleID = rule;
    cmd_bucket = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_srcIP = '0; cmd_ruleID = '0;
    cmd_bucket = '0; head_rd_addr = '0;
    for (int i = 0; i < 16; i++) exp_head[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, we, done, err_full} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got rdy/we/done/err=%b required 1000", {cmd_ready, we, done, err_full});
    end
    checks++;
    if (din !== 60'd0 || wr_index !== 11'd0 || head_rd_data !== 11'd0) begin
      errors++;
      $display("FAIL reset_data got din=%h idx=%0d head=%0d required 0", din, wr_index, head_rd_data);
    end
    checks++;
    if (free_count !== 11'd154) begin
      errors++;
      $display("FAIL reset_free got %0d required 154", free_count);
    end
    $display("reset: free_count=%0d", free_count);
  endtask

  task automatic test_insert();
    send(2'b01, 32'h0A000001, 11'd5, 4'd3);
    exp_din = {11'd0, 11'd5, 6'd0, 32'h0A000001};
    checks++;
    if (we !== 1'b1 || done !== 1'b1 || err_full !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ins1_flags got we=%0b done=%0b err=%0b rdy=%0b required 1 1 0 0", we, done, err_full, cmd_ready);
    end
    checks++;
    if (wr_index !== 11'd1 || din !== exp_din) begin
      errors++;
      $display("FAIL ins1_write got idx=%0d din=%h required 1 %h", wr_index, din, exp_din);
    end
    $display("insert1: idx=%0d din=%h", wr_index, din);
    head_rd_addr = 4'd3;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || we !== 1'b0 || done !== 1'b0 || free_count !== 11'd153) begin
      errors++;
      $display("FAIL ins1_after got rdy=%0b we=%0b done=%0b free=%0d required 1 0 0 153", cmd_ready, we, done, free_count);
    end
    @(negedge clk);
    checks++;
    if (head_rd_data !== 11'd1) begin
      errors++;
      $display("FAIL ins1_head got %0d required 1", head_rd_data);
    end
    exp_head[3] = 11'd1;
  endtask

  task automatic test_chain_head_read();
    send(2'b01, 32'h0A000002, 11'd6, 4'd3);
    exp_din = {11'd1, 11'd6, 6'd0, 32'h0A000002};
    checks++;
    if (we !== 1'b1 || wr_index !== 11'd2 || din !== exp_din) begin
      errors++;
      $display("FAIL ins2_write got we=%0b idx=%0d din=%h required 1 2 %h", we, wr_index, din, exp_din);
    end
    $display("insert2: idx=%0d next=%0d", wr_index, din[59:49]);
    exp_head[3] = 11'd2;
    @(negedge clk);
    head_rd_addr = 4'd0;
    @(negedge clk);
    checks++;
    if (head_rd_data !== 11'd0) begin
      errors++;
      $display("FAIL head_b0 got %0d required 0", head_rd_data);
    end
    head_rd_addr = 4'd3;
    @(negedge clk);
    checks++;
    if (head_rd_data !== 11'd2) begin
      errors++;
      $display("FAIL head_b3 got %0d required 2", head_rd_data);
    end
  endtask

  task automatic test_fill_full();
    for (int k = 3; k <= 154; k++) begin
      send(2'b01, 32'(k), 11'(k), 4'(k % 16));
      checks++;
      if (we !== 1'b1 || wr_index !== 11'(k) || din[59:49] !== exp_head[k % 16]) begin
        errors++;
        $display("FAIL fill_%0d got we=%0b idx=%0d next=%0d required 1 %0d %0d", k, we, wr_index, din[59:49], k, exp_head[k % 16]);
      end
      exp_head[k % 16] = 11'(k);
    end
    send(2'b01, 32'hFFFF0000, 11'd99, 4'd5);
    checks++;
    if (done !== 1'b1 || err_full !== 1'b1 || we !== 1'b0) begin
      errors++;
      $display("FAIL full_ins got done=%0b err=%0b we=%0b required 1 1 0", done, err_full, we);
    end
    $display("full insert: done=%0b err_full=%0b we=%0b", done, err_full, we);
    @(negedge clk);
    checks++;
    if (free_count !== 11'd0 || err_full !== 1'b0) begin
      errors++;
      $display("FAIL full_free got free=%0d err=%0b required 0 0", free_count, err_full);
    end
    for (int b = 0; b < 16; b++) begin
      head_rd_addr = 4'(b);
      @(negedge clk);
      checks++;
      if (head_rd_data !== exp_head[b]) begin
        errors++;
        $display("FAIL full_head_%0d got %0d required %0d", b, head_rd_data, exp_head[b]);
      end
    end
  endtask

  task automatic test_flush();
    int idx = 0;
    int done_idx = -1;
    send(2'b10, '0, '0, '0);
    while (we === 1'b1 && idx < 300) begin
      checks++;
      if (wr_index !== 11'(idx) || din !== 60'd0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL flush_w%0d got idx=%0d din=%h rdy=%0b required %0d 0 0", idx, wr_index, din, cmd_ready, idx);
      end
      if (done === 1'b1) done_idx = idx;
      idx++;
      @(negedge clk);
    end
    $display("flush: writes=%0d done_at=%0d", idx, done_idx);
    checks++;
    if (idx != 155 || done_idx != 154) begin
      errors++;
      $display("FAIL flush_count got writes=%0d done_at=%0d required 155 154", idx, done_idx);
    end
    checks++;
    if (cmd_ready !== 1'b1 || free_count !== 11'd154) begin
      errors++;
      $display("FAIL flush_after got rdy=%0b free=%0d required 1 154", cmd_ready, free_count);
    end
    for (int b = 0; b < 16; b++) begin
      head_rd_addr = 4'(b);
      @(negedge clk);
      checks++;
      if (head_rd_data !== 11'd0) begin
        errors++;
        $display("FAIL flush_head_%0d got %0d required 0", b, head_rd_data);
      end
      exp_head[b] = '0;
    end
  endtask

  task automatic test_noop();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || we !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL noop got done=%0b we=%0b rdy=%0b required 1 0 0", done, we, cmd_ready);
    end
    $display("noop: done=%0b we=%0b", done, we);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL noop_after got rdy=%0b done=%0b required 1 0", cmd_ready, done);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_srcIP = 32'hC0A80001;
    cmd_ruleID = 11'd7; cmd_bucket = 4'd0;
    @(negedge clk);
    exp_din = {11'd0, 11'd7, 6'd0, 32'hC0A80001};
    checks++;
    if (we !== 1'b1 || wr_index !== 11'd1 || din !== exp_din || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got we=%0b idx=%0d din=%h rdy=%0b required 1 1 %h 0", we, wr_index, din, cmd_ready, exp_din);
    end
    cmd_srcIP = 32'hDEADBEEF; cmd_ruleID = 11'd9;
    @(negedge clk);
    checks++;
    if (we !== 1'b0 || cmd_ready !== 1'b1 || din !== exp_din) begin
      errors++;
      $display("FAIL b2b_gap got we=%0b rdy=%0b din=%h required 0 1 %h", we, cmd_ready, din, exp_din);
    end
    @(negedge clk);
    exp_din = {11'd1, 11'd9, 6'd0, 32'hDEADBEEF};
    checks++;
    if (we !== 1'b1 || wr_index !== 11'd2 || din !== exp_din) begin
      errors++;
      $display("FAIL b2b_second got we=%0b idx=%0d din=%h required 1 2 %h", we, wr_index, din, exp_din);
    end
    $display("back_to_back: second idx=%0d din=%h", wr_index, din);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (we !== 1'b0 || cmd_ready !== 1'b1 || free_count !== 11'd152) begin
      errors++;
      $display("FAIL b2b_end got we=%0b rdy=%0b free=%0d required 0 1 152", we, cmd_ready, free_count);
    end
  endtask

  task automatic test_reset_mid_flush();
    int guard = 0;
    send(2'b10, '0, '0, '0);
    while (wr_index !== 11'd40 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (we !== 1'b1 || wr_index !== 11'd40) begin
      errors++;
      $display("FAIL rstflush_reach got we=%0b idx=%0d required 1 40", we, wr_index);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, we, done, err_full} !== 4'b1000 || wr_index !== 11'd0 || din !== 60'd0) begin
      errors++;
      $display("FAIL rstflush_out got rdy/we/done/err=%b idx=%0d din=%h required 1000 0 0", {cmd_ready, we, done, err_full}, wr_index, din);
    end
    checks++;
    if (free_count !== 11'd154 || head_rd_data !== 11'd0) begin
      errors++;
      $display("FAIL rstflush_state got free=%0d head=%0d required 154 0", free_count, head_rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b01, 32'h01020304, 11'd3, 4'd2);
    exp_din = {11'd0, 11'd3, 6'd0, 32'h01020304};
    checks++;
    if (we !== 1'b1 || wr_index !== 11'd1 || din !== exp_din) begin
      errors++;
      $display("FAIL rstflush_ins got we=%0b idx=%0d din=%h required 1 1 %h", we, wr_index, din, exp_din);
    end
    $display("post-reset insert: idx=%0d", wr_index);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_insert();
    test_chain_head_read();
    test_fill_full();
    test_flush();
    test_noop();
    test_back_to_back();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
